// File: rtl/rs_sched_ctrl_if.sv
// Dispatch, CDB and issue signals of one reservation-station scheduler.
// The o_occ_cnt member exists only when RS_OCC_CNT_EN is defined.
interface rs_sched_ctrl_if #(
  parameter int unsigned ENT_SEL = 2,
  parameter int unsigned TAG_W   = 6
);
  logic               i_flush;
  logic               i_dp_vld;
  logic [1:0]         i_req_num;
  logic [TAG_W-1:0]   i_src1_tag_1;
  logic [TAG_W-1:0]   i_src2_tag_1;
  logic               i_src1_rdy_1;
  logic               i_src2_rdy_1;
  logic [TAG_W-1:0]   i_src1_tag_2;
  logic [TAG_W-1:0]   i_src2_tag_2;
  logic               i_src1_rdy_2;
  logic               i_src2_rdy_2;
  logic               o_allocable;
  logic [ENT_SEL-1:0] o_alloc_ent_1;
  logic [ENT_SEL-1:0] o_alloc_ent_2;
  logic               i_cdb_vld;
  logic [TAG_W-1:0]   i_cdb_tag;
  logic               o_issue_vld;
  logic [ENT_SEL-1:0] o_issue_ent;
  logic               i_issue_rdy;
`ifdef RS_OCC_CNT_EN
  logic [ENT_SEL:0]   o_occ_cnt;
`endif

  modport master (
    output i_flush, i_dp_vld, i_req_num,
    output i_src1_tag_1, i_src2_tag_1, i_src1_rdy_1, i_src2_rdy_1,
    output i_src1_tag_2, i_src2_tag_2, i_src1_rdy_2, i_src2_rdy_2,
    output i_cdb_vld, i_cdb_tag, i_issue_rdy,
`ifdef RS_OCC_CNT_EN
    input  o_occ_cnt,
`endif
    input  o_allocable, o_alloc_ent_1, o_alloc_ent_2, o_issue_vld, o_issue_ent
  );

  modport slave (
    input  i_flush, i_dp_vld, i_req_num,
    input  i_src1_tag_1, i_src2_tag_1, i_src1_rdy_1, i_src2_rdy_1,
    input  i_src1_tag_2, i_src2_tag_2, i_src1_rdy_2, i_src2_rdy_2,
    input  i_cdb_vld, i_cdb_tag, i_issue_rdy,
`ifdef RS_OCC_CNT_EN
    output o_occ_cnt,
`endif
    output o_allocable, o_alloc_ent_1, o_alloc_ent_2, o_issue_vld, o_issue_ent
  );
endinterface

// File: rtl/rs_sched_ctrl.sv
// Reservation-station scheduler: 2-wide allocation, CDB wakeup, in-order-by-index issue.
// Define RS_OCC_CNT_EN to add the registered occupancy counter o_occ_cnt.
module rs_sched_ctrl #(
  parameter int unsigned ENT_NUM = 4,
  parameter int unsigned ENT_SEL = 2,
  parameter int unsigned TAG_W   = 6
) (
  input logic            i_clk,
  input logic            i_rst,
  rs_sched_ctrl_if.slave rs
);
  localparam int unsigned CntW = ENT_SEL + 1;

  logic [ENT_NUM-1:0] busy_q;
  logic [ENT_NUM-1:0] src1_rdy_q;
  logic [ENT_NUM-1:0] src2_rdy_q;
  logic [TAG_W-1:0]   src1_tag_q [ENT_NUM];
  logic [TAG_W-1:0]   src2_tag_q [ENT_NUM];

  logic [ENT_SEL-1:0] alloc_ent_1;
  logic [ENT_SEL-1:0] alloc_ent_2;
  logic [ENT_SEL-1:0] issue_ent;
  logic [CntW-1:0]    free_cnt;
  logic               found_1;
  logic               found_2;
  logic [ENT_NUM-1:0] rdy_vec;
  logic               allocable;
  logic               issue_vld;
  logic               dp_fire;
  logic               issue_fire;
  logic               wr_1;
  logic               wr_2;
  logic               rdy1_1, rdy2_1, rdy1_2, rdy2_2;

  always_comb begin
    alloc_ent_1 = '0;
    alloc_ent_2 = '0;
    found_1     = 1'b0;
    found_2     = 1'b0;
    free_cnt    = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busy_q[i]) begin
        free_cnt = free_cnt + CntW'(1);
        if (!found_1) begin
          alloc_ent_1 = ENT_SEL'(i);
          found_1     = 1'b1;
        end else if (!found_2) begin
          alloc_ent_2 = ENT_SEL'(i);
          found_2     = 1'b1;
        end
      end
    end
  end

  assign allocable = free_cnt >= CntW'(rs.i_req_num);
  assign dp_fire   = rs.i_dp_vld & allocable & ~rs.i_flush;
  assign wr_1      = dp_fire & (|rs.i_req_num);
  assign wr_2      = dp_fire & rs.i_req_num[1];

  // A source produced on the CDB in the dispatch cycle would otherwise miss its wakeup.
  assign rdy1_1 = rs.i_src1_rdy_1 | (rs.i_cdb_vld & (rs.i_cdb_tag == rs.i_src1_tag_1));
  assign rdy2_1 = rs.i_src2_rdy_1 | (rs.i_cdb_vld & (rs.i_cdb_tag == rs.i_src2_tag_1));
  assign rdy1_2 = rs.i_src1_rdy_2 | (rs.i_cdb_vld & (rs.i_cdb_tag == rs.i_src1_tag_2));
  assign rdy2_2 = rs.i_src2_rdy_2 | (rs.i_cdb_vld & (rs.i_cdb_tag == rs.i_src2_tag_2));

  assign rdy_vec = busy_q & src1_rdy_q & src2_rdy_q;

  always_comb begin
    issue_ent = '0;
    issue_vld = 1'b0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        issue_ent = ENT_SEL'(i);
        issue_vld = 1'b1;
      end
    end
  end

  assign issue_fire = issue_vld & rs.i_issue_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q     <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
      end
    end else if (rs.i_flush) begin
      busy_q     <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (rs.i_cdb_vld && busy_q[i]) begin
          if (src1_tag_q[i] == rs.i_cdb_tag) src1_rdy_q[i] <= 1'b1;
          if (src2_tag_q[i] == rs.i_cdb_tag) src2_rdy_q[i] <= 1'b1;
        end
        if (issue_fire && (issue_ent == ENT_SEL'(i))) busy_q[i] <= 1'b0;
        // Allocated entries are free in busy_q, so they never collide with wakeup or issue.
        if (wr_1 && (alloc_ent_1 == ENT_SEL'(i))) begin
          busy_q[i]     <= 1'b1;
          src1_tag_q[i] <= rs.i_src1_tag_1;
          src2_tag_q[i] <= rs.i_src2_tag_1;
          src1_rdy_q[i] <= rdy1_1;
          src2_rdy_q[i] <= rdy2_1;
        end else if (wr_2 && (alloc_ent_2 == ENT_SEL'(i))) begin
          busy_q[i]     <= 1'b1;
          src1_tag_q[i] <= rs.i_src1_tag_2;
          src2_tag_q[i] <= rs.i_src2_tag_2;
          src1_rdy_q[i] <= rdy1_2;
          src2_rdy_q[i] <= rdy2_2;
        end
      end
    end
  end

`ifdef RS_OCC_CNT_EN
  logic [CntW-1:0] occ_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_cnt_q <= '0;
    end else if (rs.i_flush) begin
      occ_cnt_q <= '0;
    end else begin
      occ_cnt_q <= occ_cnt_q + (dp_fire ? CntW'(rs.i_req_num) : '0) - CntW'(issue_fire);
    end
  end

  assign rs.o_occ_cnt = occ_cnt_q;
`endif

  assign rs.o_allocable   = allocable;
  assign rs.o_alloc_ent_1 = alloc_ent_1;
  assign rs.o_alloc_ent_2 = alloc_ent_2;
  assign rs.o_issue_vld   = issue_vld;
  assign rs.o_issue_ent   = issue_ent;

endmodule

// File: doc/rs_sched_ctrl.md
Name: rs_sched_ctrl

Overview:
- Sequential scheduler for one out-of-order reservation station.
- Owns per-entry busy, source-ready and source-tag state, and accepts up to 2 dispatched instructions per cycle.
- Snoops one CDB result tag per cycle for wakeup, and issues one ready entry per cycle to its execution unit over a valid/ready handshake.
- Outputs entry indices that address the station's payload RAM; sits between the dispatch stage and one execution pipe.

Parameters:
- ENT_NUM, 4, number of station entries (power of 2, >=2).
- ENT_SEL, 2, log2(ENT_NUM), entry index width.
- TAG_W, 6, physical register tag width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_flush  in  1  pipeline flush; clears all entries.
- i_dp_vld  in  1  dispatch request valid.
- i_req_num  in  2  number of instructions dispatched this cycle (0..2; 3 is illegal).
- i_src1_tag_1, i_src2_tag_1  in  TAG_W each  source tags, slot 1.
- i_src1_rdy_1, i_src2_rdy_1  in  1 each  source already available, slot 1.
- i_src1_tag_2, i_src2_tag_2, i_src1_rdy_2, i_src2_rdy_2  in  as slot 1  slot 2 sources.
- o_allocable  out  1  free entries >= i_req_num.
- o_alloc_ent_1, o_alloc_ent_2  out  ENT_SEL each  payload write indices for slots 1 and 2.
- i_cdb_vld  in  1  result broadcast valid.
- i_cdb_tag  in  TAG_W  broadcast tag.
- o_issue_vld  out  1  an entry is ready to issue.
- o_issue_ent  out  ENT_SEL  index of the entry being issued.
- i_issue_rdy  in  1  execution unit accepts the issue.

Behaviour:
- Reset (async) and i_flush (sync) clear all busy, rdy and tag state. With every entry free, o_issue_vld=0, o_issue_ent=0, o_allocable=1, o_alloc_ent_1=0, o_alloc_ent_2=1.
- Allocation (combinational from registered busy):
  - alloc_ent_1 = lowest-index free entry; alloc_ent_2 = next lowest free entry.
  - o_allocable = popcount(~busy) >= i_req_num; i_req_num=0 gives 1.
- Fire: dp_fire = i_dp_vld & o_allocable & ~i_flush.
  - On dp_fire the chosen entries set busy and capture tags/rdy at the clock edge.
  - i_req_num=1 writes only slot 1.
  - If o_allocable=0 nothing is written; dispatch must stall.
- Wakeup: on i_cdb_vld, every busy entry whose tag matches i_cdb_tag sets that source rdy at the edge.
- Same-cycle wakeup bypass: a dispatched source whose tag equals i_cdb_tag with i_cdb_vld=1 is written rdy=1.
- Ready vector: rdy_vec[i] = busy & src1_rdy & src2_rdy, taken from registered state only.
  - Earliest issue is 1 cycle after dispatch or after the wakeup edge.
  - No combinational CDB-to-issue path.
- Issue:
  - o_issue_vld = |rdy_vec; o_issue_ent = lowest-index ready entry.
  - issue_fire = o_issue_vld & i_issue_rdy. On issue_fire the entry's busy clears at the edge.
  - If i_issue_rdy=0, o_issue_vld and o_issue_ent stay stable unless a lower-index entry becomes ready (no hold requirement; the consumer samples only on fire).
- Simultaneous issue and dispatch: an entry freed by issue_fire is not allocatable until the next cycle, because allocation uses registered busy.
- Flush priority: flush > issue/dispatch/wakeup. During a flush cycle o_issue_vld still reflects current state, but the edge result is all entries free.
- Slot 2 with i_req_num=2 always gets a different index than slot 1. When o_allocable=0, the alloc_ent values are don't-care.

Optional Feature:
- RS_OCC_CNT_EN.
- Defined: adds output o_occ_cnt [ENT_SEL:0], a registered occupancy counter.
  - Reset and flush set it to 0.
  - Each cycle it updates to cnt + (dp_fire ? i_req_num : 0) - issue_fire.
  - It must always equal popcount(busy); the bench checks this every cycle.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then dispatch 2 instructions with all rdy=1 -> entries 0,1 written. Next cycle o_issue_vld=1, o_issue_ent=0; with i_issue_rdy=1, entry 1 issues the following cycle and entry 0 is free.
- Fill all 4 entries with src1_rdy=0, tag=5, then i_req_num=1 -> o_allocable=0 and no write. After i_cdb_tag=5 -> issue_vld=1 the next cycle, entries issue in order 0,1,2,3.
- Dispatch slot 1 with src1_tag=9, rdy=0, while i_cdb_vld=1 with tag=9 in the same cycle -> entry ready and issuable the next cycle.
- i_issue_rdy held 0 for 3 cycles with entry 2 ready -> o_issue_ent=2 stable. Entry 0 then becomes ready -> o_issue_ent=0.
- 3 entries busy, i_req_num=2 -> o_allocable=0. In the same cycle entry 1 issues -> the next cycle o_allocable=1 with alloc_ent_1=1, alloc_ent_2=3.
- i_flush with 3 busy entries and a concurrent dispatch -> all free next cycle, o_issue_vld=0; with RS_OCC_CNT_EN, o_occ_cnt=0. Assert i_rst mid-issue -> outputs go to reset values immediately.
